// File: rtl/gray_counter_if.sv
// gray_counter_if: control and status bundle of the Gray-code counter
//   en, up, load, load_bin : count enable, direction, synchronous load and its value (master -> slave)
//   bin_out, gray_out      : registered binary count and its Gray code (slave -> master)
//   wrap, sat              : wrap pulse and saturation level (slave -> master)
interface gray_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;
    logic             sat;
    modport master(output en, up, load, load_bin, input bin_out, gray_out, wrap, sat);
    modport slave(input en, up, load, load_bin, output bin_out, gray_out, wrap, sat);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray-code counter with load, wrap/saturate modes and status
//   clk : rising-edge clock
//   rst : asynchronous active-high reset to RESET_VAL
//   io  : gray_counter_if slave (en, up, load, load_bin in; bin_out, gray_out, wrap, sat out)
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input logic          clk,
    input logic          rst,
    gray_counter_if.slave io
);
    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
    logic             at_lim;
    logic             hold;
    logic             wrap_next;
    logic             sat_next;
    logic [WIDTH-1:0] bin_next;
    // at_lim: an enabled step is requested past the end of the range
    always_comb begin
        at_lim    = io.en && (io.up ? io.bin_out == MAX : io.bin_out == '0);
        hold      = SATURATE && at_lim;
        bin_next  = io.load ? io.load_bin :
                    (!io.en || hold) ? io.bin_out :
                    io.up ? io.bin_out + ONE : io.bin_out - ONE;
        wrap_next = !SATURATE && !io.load && at_lim;
        sat_next  = SATURATE && !io.load && at_lim;
    end
    // Gray code is derived from the next binary value so both views update on one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.bin_out  <= RESET_VAL;
            io.gray_out <= RST_GRAY;
            io.wrap     <= 1'b0;
            io.sat      <= 1'b0;
        end else begin
            io.bin_out  <= bin_next;
            io.gray_out <= bin_next ^ (bin_next >> 1);
            io.wrap     <= wrap_next;
            io.sat      <= sat_next;
        end
    end
endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Parametrised up/down Gray-code counter. It extends the team's 4-bit combinational binary-to-Gray converter into a registered, width-generic counter with enable, load, direction, saturate/wrap modes and status pulses. It is intended for clock-domain-crossing pointers (async FIFO read/write pointers) and for position encoders. Binary and Gray views are both registered and always consistent in the same cycle.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
RESET_VAL, 0, binary value loaded on reset; must fit in WIDTH bits.
SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at max/min.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; one step per cycle while high.
up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
load  input  1  synchronous load of load_bin; priority over en.
load_bin  input  WIDTH  binary value to load.
bin_out  output  WIDTH  registered binary count.
gray_out  output  WIDTH  registered Gray code of bin_out.
wrap  output  1  one-cycle pulse: the previous step wrapped (SATURATE=0 only).
sat  output  1  level: the counter is held at a limit (SATURATE=1 only).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, asynchronous and immediate on rst high:
  - bin_out = RESET_VAL; gray_out = RESET_VAL ^ (RESET_VAL >> 1).
  - wrap = 0; sat = 0.
  - While rst is high, all inputs are ignored.
  - Counting resumes on the first rising clk edge after rst deasserts.
- Gray rule, all WIDTH bits:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1.
- Single-register update: gray_out is computed from the next binary value and registered on the same edge as bin_out. There is no cycle where gray_out != gray(bin_out).
- Per-edge priority: load, then en, then hold.
  - load=1: bin_out = load_bin. gray_out updates correspondingly. wrap = 0. sat recomputed (see below). en and up are ignored.
  - en=1, up=1: bin_out + 1, modulo 2^WIDTH.
  - en=1, up=0: bin_out - 1, modulo 2^WIDTH.
  - en=0, load=0: all registers hold. wrap clears to 0.
- Wrap mode (SATURATE=0):
  - Increment from all-ones gives 0; decrement from 0 gives all-ones.
  - wrap is registered: high for exactly the cycle after the edge that wrapped.
  - sat is tied to 0.
- Saturate mode (SATURATE=1):
  - An increment request at all-ones leaves bin_out at all-ones.
  - A decrement request at 0 leaves bin_out at 0.
  - sat is registered. It is 1 while bin_out sits at the limit in the requested direction and en=1 on the last edge. It is 0 after any edge with en=0 that is not a load.
  - Loading to a limit sets sat=0.
  - wrap is tied to 0.
- Single-bit property: every en-driven step (no load, no saturate hold) changes exactly one bit of gray_out. A load may change any number of bits.
- Direction changes take effect on the same edge; no extra cycles.
- Latency: one clk edge from input to bin_out, gray_out, wrap and sat.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=5, assert rst mid-count at bin=9 -> bin_out=5 and gray_out=4'b0111 immediately, before the next edge; wrap=0, sat=0.
- Up wrap: WIDTH=4, en=1, up=1 for 20 cycles from 0 -> gray sequence 0000,0001,0011,0010,...,1000 then 0000. Exactly one gray bit toggles per step. wrap pulses once, in the cycle after bin goes 15->0.
- Down wrap and direction change: from bin=1, up=0 for 2 cycles -> 0 then 15 (gray 1000), with a wrap pulse. Then up=1 for 1 cycle -> 0, with a wrap pulse.
- Load priority: load=1, en=1, up=1, load_bin=4'hA -> bin_out=10, gray_out=4'b1111, wrap=0. On the next edge with en only -> 11, gray 1110.
- Saturate: SATURATE=1, WIDTH=4, load 14, then en=1, up=1 for 3 cycles -> 15, 15, 15 with sat=1 from the second edge. Then up=0 -> 14, sat=0. wrap stays 0 throughout.
- Width sweep: WIDTH=8, 300 random en/up/load cycles checked against a reference model -> gray_out == bin ^ (bin >> 1) every cycle, and the modulo-256 arithmetic matches.
